mem_dstb: RTL
=============

# mem_dstb

Parametrised 1-to-NUM_SLV memory-access distributor for the MEM stage. It generalises the fixed memory/CLINT split to any number of address-decoded slave channels. Each request from the memory interface is registered, decoded against per-slave base/mask regions and forwarded to exactly one slave. The block then returns the slave's data and response, a decode error or a timeout error to the requester. It sits between the memory interface and the external bus, CLINT and future MMIO slaves.

## Interface
- NUM_SLV, 2: number of slave channels (1..8).
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- SLV_BASE, {64'h0200_0000, 64'h8000_0000}: flattened NUM_SLV*ADDR_W bases; slice i = slave i.
- SLV_MASK, {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_8000_0000}: flattened region masks.
- TIMEOUT, 255: max BUSY cycles before error; 0 disables timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2^CNT_W.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- mem_dstb_valid_i  in  1  upstream request valid.
- mem_dstb_ready_o  out  1  upstream completion, one-cycle pulse.
- mem_dstb_req_i  in  1  1 = write, 0 = read.
- mem_dstb_addr_i  in  ADDR_W  request address.
- mem_dstb_data_write_i  in  DATA_W  write data.
- mem_dstb_size_i  in  2  access size: 0=B, 1=H, 2=W, 3=D.
- mem_dstb_data_read_o  out  DATA_W  read data.
- mem_dstb_resp_o  out  2  response: 00 OKAY, 10 SLVERR or timeout, 11 DECERR.
- mem_dstb_skip_o  out  1  difftest skip: completed access targeted slave index ≠ 0.
- mem_dstb_slv_valid_o  out  NUM_SLV  one-hot per-slave valid.
- mem_dstb_slv_ready_i  in  NUM_SLV  per-slave ready.
- mem_dstb_slv_req_o / _addr_o / _data_write_o / _size_o  out  1/ADDR_W/DATA_W/2  shared, registered request fields.
- mem_dstb_slv_data_read_i  in  NUM_SLV*DATA_W  per-slave read data.
- mem_dstb_slv_resp_i  in  NUM_SLV*2  per-slave response.

## Operation
- States: IDLE, BUSY, ERR, DONE. Reset state is IDLE.
- Region decode: slave i hits when (addr & MASK_i) == BASE_i. If several slaves hit, the lowest index wins.
- IDLE:
  - mem_dstb_valid_i=1: latch req, addr, data and size; latch the decoded index.
  - Hit → BUSY. No hit → ERR.
- BUSY:
  - slv_valid_o[idx]=1 with the latched fields on the shared outputs.
  - slv_ready_i[idx]=1: capture the slave's data_read and resp → DONE.
  - Else, if TIMEOUT≠0 and the counter equals TIMEOUT-1: data=0, resp=10 → DONE.
  - Counter clears on entry to BUSY and increments each BUSY cycle.
- ERR: data=0, resp=11 → DONE. No slave valid is asserted.
- DONE:
  - ready_o=1 with the registered data_read_o and resp_o.
  - skip_o=1 if idx≠0 and the state was not reached through ERR.
  - → IDLE.
- Ready signals of non-selected slaves are ignored.
- A slave ready arriving after a timeout is ignored.
- The upstream request is sampled only in IDLE. The requester must deassert valid in the cycle after ready; if valid is still high in IDLE, a new transaction starts.
- Upstream inputs changing during BUSY, ERR or DONE have no effect.

## Timing
- Reset (rst=0, asynchronous) values:
  - state IDLE.
  - ready_o, skip_o and slv_valid_o all 0.
  - data_read_o, resp_o and all latched fields 0.
  - timeout counter 0.
- Reset asserted mid-transaction aborts immediately. The slave valid drops in the same reset assertion; no completion is issued.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency, slave with zero-wait ready:
  - valid sampled at cycle 0.
  - slv_valid high in cycle 1, slave ready in cycle 1.
  - ready_o in cycle 2, i.e. 2 cycles to completion.
- Slave ready after k extra cycles: ready_o at cycle 2+k.
- Decode error: ready_o at cycle 2.
- Timeout: ready_o at cycle TIMEOUT+1.
- slv_valid_o stays high and stable until the slave's ready or timeout. Data and resp outputs are held stable while ready_o=1.

## Test plan
- Read 0x8000_1000, size 3; slave 0 returns ready at cycle 1 with data 64'hDEAD_BEEF_0123_4567 and resp 00 → ready_o at cycle 2 carrying that data, resp 00, skip 0.
- Write 0x0200_4000 data 64'h5; slave 1 ready after 3 waits → slv_valid_o=2'b10 for 4 cycles with addr and data stable; ready_o at cycle 5, skip 1.
- Read 0x1000_0000, which hits no slave → no slv_valid_o; ready_o at cycle 2, resp 11, data 0.
- TIMEOUT=4, slave 0 never ready → slv_valid_o high for cycles 1–4; ready_o at cycle 5, resp 10, data 0. A late slave ready at cycle 6 is ignored.
- Overlapping regions with an address matching slaves 0 and 1 → only slv_valid_o[0] is asserted. Back-to-back: valid held high → second transaction starts in the IDLE cycle following DONE.
- rst low while in BUSY → all outputs 0 asynchronously. After release, a new read completes normally at cycle 2.

Source files
------------

// File: rtl/mem_dstb.sv
// Memory-stage request distributor: one upstream requester fanned out to NUM_SLV
// address-decoded slave channels, with decode-error and timeout responses.
module mem_dstb #(
    parameter int unsigned               NUM_SLV  = 2,
    parameter int unsigned               ADDR_W   = 64,
    parameter int unsigned               DATA_W   = 64,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {64'h0000_0000_0200_0000, 64'h0000_0000_8000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_8000_0000},
    parameter int unsigned               TIMEOUT  = 255,
    parameter int unsigned               CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_dstb_valid_i,
    output logic                      mem_dstb_ready_o,
    input  logic                      mem_dstb_req_i,
    input  logic [ADDR_W-1:0]         mem_dstb_addr_i,
    input  logic [DATA_W-1:0]         mem_dstb_data_write_i,
    input  logic [1:0]                mem_dstb_size_i,
    output logic [DATA_W-1:0]         mem_dstb_data_read_o,
    output logic [1:0]                mem_dstb_resp_o,
    output logic                      mem_dstb_skip_o,
    output logic [NUM_SLV-1:0]        mem_dstb_slv_valid_o,
    input  logic [NUM_SLV-1:0]        mem_dstb_slv_ready_i,
    output logic                      mem_dstb_slv_req_o,
    output logic [ADDR_W-1:0]         mem_dstb_slv_addr_o,
    output logic [DATA_W-1:0]         mem_dstb_slv_data_write_o,
    output logic [1:0]                mem_dstb_slv_size_o,
    input  logic [NUM_SLV*DATA_W-1:0] mem_dstb_slv_data_read_i,
    input  logic [NUM_SLV*2-1:0]      mem_dstb_slv_resp_i
);

    localparam int unsigned      IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic                ready_q;
    logic                skip_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic [NUM_SLV-1:0]  slv_valid_q;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          size_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                hit_c;
    logic [IDX_W-1:0]    hit_idx_c;
    logic [NUM_SLV-1:0]  onehot_c;
    logic                sel_ready_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic [1:0]          sel_resp_c;

    // Region decode; scanning downward leaves the lowest matching index.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        onehot_c  = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((mem_dstb_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
        onehot_c[hit_idx_c] = hit_c;
    end

    // Response path of the latched slave only.
    always_comb begin
        sel_ready_c = mem_dstb_slv_ready_i[idx_q];
        sel_data_c  = mem_dstb_slv_data_read_i[32'(idx_q)*DATA_W +: DATA_W];
        sel_resp_c  = mem_dstb_slv_resp_i[32'(idx_q)*2 +: 2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            skip_q      <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            slv_valid_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            ready_q <= 1'b0;
            skip_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_dstb_valid_i) begin
                        req_q   <= mem_dstb_req_i;
                        addr_q  <= mem_dstb_addr_i;
                        wdata_q <= mem_dstb_data_write_i;
                        size_q  <= mem_dstb_size_i;
                        idx_q   <= hit_idx_c;
                        cnt_q   <= '0;
                        if (hit_c) begin
                            slv_valid_q <= onehot_c;
                            state_q     <= S_BUSY;
                        end else begin
                            state_q <= S_ERR;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sel_ready_c) begin
                        rdata_q     <= sel_data_c;
                        resp_q      <= sel_resp_c;
                        slv_valid_q <= '0;
                        ready_q     <= 1'b1;
                        skip_q      <= (idx_q != '0);
                        state_q     <= S_DONE;
                    end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        rdata_q     <= '0;
                        resp_q      <= RESP_SLVERR;
                        slv_valid_q <= '0;
                        ready_q     <= 1'b1;
                        skip_q      <= (idx_q != '0);
                        state_q     <= S_DONE;
                    end
                end
                S_ERR: begin
                    rdata_q <= '0;
                    resp_q  <= RESP_DECERR;
                    ready_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    resp_q  <= RESP_OKAY;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_dstb_ready_o          = ready_q;
    assign mem_dstb_skip_o           = skip_q;
    assign mem_dstb_data_read_o      = rdata_q;
    assign mem_dstb_resp_o           = resp_q;
    assign mem_dstb_slv_valid_o      = slv_valid_q;
    assign mem_dstb_slv_req_o        = req_q;
    assign mem_dstb_slv_addr_o       = addr_q;
    assign mem_dstb_slv_data_write_o = wdata_q;
    assign mem_dstb_slv_size_o       = size_q;

endmodule
